// File: rtl/lfsr_draw_ctrl.sv
// Sequences a shared 64-bit LFSR: owns seeding, enforces a warm-up of STEPS shifts
// between delivered words, and arbitrates draws round-robin between two requesters.
module lfsr_draw_ctrl #(
    parameter int unsigned STEPS        = 64,
    parameter logic [63:0] DEFAULT_SEED = 64'hACE1_ACE1_ACE1_ACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_req,
    input  logic [63:0] seed_in,
    output logic        seed_ack,
    input  logic [1:0]  req,
    output logic [1:0]  grant,
    output logic [63:0] rnd_data,
    output logic        busy,
    output logic        lfsr_load,
    output logic [63:0] lfsr_seed,
    input  logic [63:0] lfsr_q
);

    localparam int unsigned W  = 64;
    localparam int unsigned CW = 8;
    localparam int unsigned NR = 2;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WARM  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [W-1:0]    seed_reg, seed_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            rr_last, rr_d;
    logic [NR-1:0]   grant_d;
    logic [W-1:0]    rnd_d;
    logic            ack_d;
    logic [W-1:0]    seed_sel;
    logic            winner;
    logic            warm_done;

    // An all-ones seed locks up an XNOR LFSR, so it is replaced by the default.
    assign seed_sel  = (seed_in == '1) ? DEFAULT_SEED : seed_in;
    assign warm_done = (cnt == CW'(STEPS - 1));

    assign lfsr_load = (state == LOAD);
    assign busy      = (state != READY);
    assign lfsr_seed = seed_reg;

    // Sole requester wins outright; on contention the one not served last wins.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~rr_last;
        endcase
    end

    always_comb begin
        state_d = state;
        seed_d  = seed_reg;
        cnt_d   = cnt;
        rr_d    = rr_last;
        grant_d = '0;
        rnd_d   = rnd_data;
        ack_d   = 1'b0;
        case (state)
            LOAD: begin
                state_d = WARM;
                cnt_d   = '0;
            end
            WARM: begin
                if (seed_req) begin
                    seed_d  = seed_sel;
                    ack_d   = 1'b1;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (warm_done) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (seed_req) begin
                    seed_d  = seed_sel;
                    ack_d   = 1'b1;
                    state_d = LOAD;
                end else if (req != '0) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    rnd_d   = lfsr_q;
                    rr_d    = winner;
                    state_d = WARM;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            seed_reg <= DEFAULT_SEED;
            cnt      <= '0;
            rr_last  <= 1'b1;
            grant    <= '0;
            rnd_data <= '0;
            seed_ack <= 1'b0;
        end else begin
            state    <= state_d;
            seed_reg <= seed_d;
            cnt      <= cnt_d;
            rr_last  <= rr_d;
            grant    <= grant_d;
            rnd_data <= rnd_d;
            seed_ack <= ack_d;
        end
    end

endmodule
